// File: rtl/mac_operand_feeder.sv
// Operand FIFO and dot-product framer in front of the TPU MAC: clear, issue pairs, drain, strobe.
// Optional FEEDER_NEG_ZERO_FILTER_EN: issued operands equal to 8'h80 are driven as 8'h00.
module mac_operand_feeder #(
   parameter int DEPTH   = 8,
   parameter int MAC_LAT = 1
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   wr_valid,
   output logic                   wr_ready,
   input  logic [7:0]             wr_a,
   input  logic [7:0]             wr_b,
   input  logic                   wr_last,
   output logic [7:0]             mac_in1,
   output logic [7:0]             mac_in2,
   output logic                   mac_clr,
   output logic                   mac_out_HL,
   output logic [$clog2(DEPTH):0] fifo_count,
   output logic                   busy,
   output logic                   underrun
);
   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;
   localparam int LW = (MAC_LAT > 1) ? $clog2(MAC_LAT) : 1;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      CLEAR  = 3'd1,
      ISSUE  = 3'd2,
      DRAIN  = 3'd3,
      STROBE = 3'd4
   } state_t;

   logic [16:0]   mem_r [DEPTH];
   logic [AW-1:0] wptr_r;
   logic [AW-1:0] rptr_r;
   logic [CW-1:0] count_r;
   logic          wr_ready_r;
   state_t        state_r;
   logic [LW-1:0] lat_r;
   logic [7:0]    in1_r;
   logic [7:0]    in2_r;
   logic          clr_r;
   logic          strobe_r;
   logic          busy_r;
   logic          underrun_r;

   logic          push_s;
   logic          pop_s;
   logic [16:0]   head_s;
   logic [CW-1:0] count_nxt_s;

   function automatic logic [7:0] issue_operand(input logic [7:0] x);
`ifdef FEEDER_NEG_ZERO_FILTER_EN
      if (x == 8'h80) begin
         return 8'h00;
      end else begin
         return x;
      end
`else
      return x;
`endif
   endfunction

   // Handshake, pop decision and next FIFO occupancy.
   always_comb begin
      push_s      = wr_valid && wr_ready_r;
      pop_s       = (state_r == ISSUE) && (count_r != {CW{1'b0}});
      head_s      = mem_r[rptr_r];
      count_nxt_s = count_r;
      case ({push_s, pop_s})
         2'b10:   count_nxt_s = count_r + 1'b1;
         2'b01:   count_nxt_s = count_r - 1'b1;
         default: count_nxt_s = count_r;
      endcase
   end

   // FIFO storage and pointers; wr_ready tracks the occupancy it will have next cycle.
   always_ff @(posedge clk) begin
      if (reset) begin
         wptr_r     <= {AW{1'b0}};
         rptr_r     <= {AW{1'b0}};
         count_r    <= {CW{1'b0}};
         wr_ready_r <= 1'b0;
      end else begin
         if (push_s) begin
            mem_r[wptr_r] <= {wr_last, wr_a, wr_b};
            wptr_r        <= wptr_r + 1'b1;
         end
         if (pop_s) begin
            rptr_r <= rptr_r + 1'b1;
         end
         count_r    <= count_nxt_s;
         wr_ready_r <= (count_nxt_s != CW'(DEPTH));
      end
   end

   // Vector framing FSM with registered MAC-side outputs.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_r    <= IDLE;
         lat_r      <= {LW{1'b0}};
         in1_r      <= 8'h00;
         in2_r      <= 8'h00;
         clr_r      <= 1'b0;
         strobe_r   <= 1'b0;
         busy_r     <= 1'b0;
         underrun_r <= 1'b0;
      end else begin
         in1_r    <= 8'h00;
         in2_r    <= 8'h00;
         clr_r    <= 1'b0;
         strobe_r <= 1'b0;
         busy_r   <= (state_r != IDLE) || (count_r != {CW{1'b0}});
         case (state_r)
            IDLE: begin
               if (count_r != {CW{1'b0}}) begin
                  state_r <= CLEAR;
               end
            end
            CLEAR: begin
               clr_r   <= 1'b1;
               state_r <= ISSUE;
            end
            ISSUE: begin
               if (pop_s) begin
                  in1_r <= issue_operand(head_s[15:8]);
                  in2_r <= issue_operand(head_s[7:0]);
                  if (head_s[16]) begin
                     lat_r   <= LW'(MAC_LAT - 1);
                     state_r <= DRAIN;
                  end
               end else begin
                  underrun_r <= 1'b1;
               end
            end
            DRAIN: begin
               if (lat_r == {LW{1'b0}}) begin
                  state_r <= STROBE;
               end else begin
                  lat_r <= lat_r - 1'b1;
               end
            end
            STROBE: begin
               strobe_r <= 1'b1;
               state_r  <= IDLE;
            end
            default: begin
               state_r <= IDLE;
            end
         endcase
      end
   end

   assign wr_ready   = wr_ready_r;
   assign mac_in1    = in1_r;
   assign mac_in2    = in2_r;
   assign mac_clr    = clr_r;
   assign mac_out_HL = strobe_r;
   assign fifo_count = count_r;
   assign busy       = busy_r;
   assign underrun   = underrun_r;
endmodule

// File: tb/tb_mac_operand_feeder.sv
// Bench for mac_operand_feeder: cycle traces checked against a transaction-timing model.
module tb_mac_operand_feeder;
   localparam int DEPTH   = 8;
   localparam int MAC_LAT = 1;
   localparam int NCYC    = 100;
   localparam int BIG     = 1 << 30;

   logic       clk = 1'b0;
   logic       reset;
   logic       wr_valid;
   logic       wr_ready;
   logic [7:0] wr_a;
   logic [7:0] wr_b;
   logic       wr_last;
   logic [7:0] mac_in1;
   logic [7:0] mac_in2;
   logic       mac_clr;
   logic       mac_out_HL;
   logic [3:0] fifo_count;
   logic       busy;
   logic       underrun;

   int errors = 0;
   int checks = 0;

   typedef struct {
      int         gap;
      logic [7:0] a;
      logic [7:0] b;
      logic       last;
   } pair_t;

   pair_t stim[$];
   int    pcyc[$];

   logic [7:0] o_in1 [NCYC];
   logic [7:0] o_in2 [NCYC];
   logic       o_clr [NCYC];
   logic       o_hl  [NCYC];
   logic       o_ur  [NCYC];
   logic       o_rdy [NCYC];
   logic       o_busy[NCYC];
   logic [3:0] o_cnt [NCYC];
   logic [7:0] e_in1 [NCYC];
   logic [7:0] e_in2 [NCYC];
   logic       e_clr [NCYC];
   logic       e_hl  [NCYC];
   logic       e_ur  [NCYC];
   logic       e_rdy [NCYC];
   logic       e_busy[NCYC];
   logic [3:0] e_cnt [NCYC];

   mac_operand_feeder #(.DEPTH(DEPTH), .MAC_LAT(MAC_LAT)) dut (
      .clk(clk), .reset(reset), .wr_valid(wr_valid), .wr_ready(wr_ready),
      .wr_a(wr_a), .wr_b(wr_b), .wr_last(wr_last),
      .mac_in1(mac_in1), .mac_in2(mac_in2), .mac_clr(mac_clr), .mac_out_HL(mac_out_HL),
      .fifo_count(fifo_count), .busy(busy), .underrun(underrun)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, got running required finished");
      $fatal(1);
   end

   function automatic logic [7:0] filt(input logic [7:0] x);
`ifdef FEEDER_NEG_ZERO_FILTER_EN
      return (x == 8'h80) ? 8'h00 : x;
`else
      return x;
`endif
   endfunction

   function automatic logic [24:0] obs_word(input int c);
      return {o_in1[c], o_in2[c], o_clr[c], o_hl[c], o_ur[c], o_rdy[c], o_busy[c], o_cnt[c]};
   endfunction

   function automatic logic [24:0] exp_word(input int c);
      return {e_in1[c], e_in2[c], e_clr[c], e_hl[c], e_ur[c], e_rdy[c], e_busy[c], e_cnt[c]};
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      reset    = 1'b1;
      wr_valid = 1'b0;
      tick();
      tick();
      reset = 1'b0;
      tick();
      tick();
   endtask

   task automatic add(input int gap, input logic [7:0] a, input logic [7:0] b, input logic last);
      pair_t p;
      p.gap  = gap;
      p.a    = a;
      p.b    = b;
      p.last = last;
      stim.push_back(p);
   endtask

   // Drives the stimulus queue, honouring wr_ready, and records outputs for n cycles.
   task automatic play(input int n);
      int k;
      int next_ok;
      k = 0;
      next_ok = (stim.size() > 0) ? stim[0].gap : BIG;
      pcyc.delete();
      for (int c = 0; c < n; c++) begin
         o_in1[c] = mac_in1;  o_in2[c] = mac_in2;  o_clr[c] = mac_clr;  o_hl[c] = mac_out_HL;
         o_ur[c]  = underrun; o_rdy[c] = wr_ready; o_busy[c] = busy;    o_cnt[c] = fifo_count;
         if (k < stim.size() && c >= next_ok) begin
            wr_valid = 1'b1;
            wr_a     = stim[k].a;
            wr_b     = stim[k].b;
            wr_last  = stim[k].last;
            if (wr_ready) begin
               pcyc.push_back(c);
               k++;
               if (k < stim.size()) next_ok = c + 1 + stim[k].gap;
            end
         end else begin
            wr_valid = 1'b0;
         end
         tick();
      end
      wr_valid = 1'b0;
   endtask

   // Expected trace from accepted push cycles and the framing timing rules.
   task automatic build_model(input int n);
      int  s_prev, clr_v, x, nx, stb, first_bub, i, np;
      bit  lastf;
      int  popc[$];
      int  win_lo[$];
      int  win_hi[$];
      for (int c = 0; c < NCYC; c++) begin
         e_in1[c] = 8'h00; e_in2[c] = 8'h00; e_clr[c] = 1'b0; e_hl[c] = 1'b0;
         e_ur[c] = 1'b0; e_rdy[c] = 1'b0; e_busy[c] = 1'b0; e_cnt[c] = 4'd0;
      end
      s_prev = 0; first_bub = BIG; i = 0; np = pcyc.size();
      while (i < np) begin
         clr_v = ((pcyc[i] + 1 > s_prev) ? pcyc[i] + 1 : s_prev) + 2;
         if (clr_v < NCYC) e_clr[clr_v] = 1'b1;
         x = clr_v - 1;
         lastf = 1'b0;
         while (!lastf && i < np) begin
            nx = (pcyc[i] + 1 > x + 1) ? pcyc[i] + 1 : x + 1;
            if (nx > x + 1 && x + 1 < first_bub) first_bub = x + 1;
            x = nx;
            popc.push_back(x);
            if (x + 1 < NCYC) begin
               e_in1[x + 1] = filt(stim[i].a);
               e_in2[x + 1] = filt(stim[i].b);
            end
            lastf = stim[i].last;
            i++;
         end
         win_lo.push_back(clr_v - 1);
         if (lastf) begin
            stb = x + 1 + MAC_LAT + 1;
            if (stb < NCYC) e_hl[stb] = 1'b1;
            win_hi.push_back(stb - 1);
            s_prev = stb;
         end else begin
            if (x + 1 < first_bub) first_bub = x + 1;
            win_hi.push_back(BIG);
         end
      end
      for (int c = 0; c < n; c++) begin
         int cnt;
         cnt = 0;
         foreach (pcyc[k]) if (pcyc[k] < c) cnt++;
         foreach (popc[k]) if (popc[k] < c) cnt--;
         e_cnt[c] = 4'(cnt);
         e_rdy[c] = (cnt != DEPTH);
         e_ur[c]  = (c > first_bub);
      end
      for (int c = 1; c < n; c++) begin
         bit act;
         act = 1'b0;
         foreach (win_lo[k]) if (c - 1 >= win_lo[k] && c - 1 <= win_hi[k]) act = 1'b1;
         e_busy[c] = act || (e_cnt[c - 1] != 4'd0);
      end
   endtask

   task automatic test_reset();
      reset    = 1'b1;
      wr_valid = 1'b0;
      wr_a     = 8'h00;
      wr_b     = 8'h00;
      wr_last  = 1'b0;
      tick();
      tick();
      checks++;
      if ({wr_ready, mac_in1, mac_in2, mac_clr, mac_out_HL, fifo_count, busy, underrun} !== 25'd0) begin
         errors++;
         $display("FAIL reset_values got rdy=%b in=%h/%h clr=%b hl=%b cnt=%0d busy=%b ur=%b required all zero",
                  wr_ready, mac_in1, mac_in2, mac_clr, mac_out_HL, fifo_count, busy, underrun);
      end
      reset = 1'b0;
      tick();
      tick();
      checks++;
      if (wr_ready !== 1'b1) begin
         errors++;
         $display("FAIL ready_after_reset got %b required 1", wr_ready);
      end
   endtask

   task automatic test_single();
      do_reset();
      stim.delete();
      add(0, 8'h0D, 8'h0F, 1'b1);
      play(14);
      build_model(14);
      for (int c = 0; c < 14; c++) begin
         checks++;
         if (obs_word(c) !== exp_word(c)) begin
            errors++;
            $display("FAIL single cyc=%0d got=%h required=%h", c, obs_word(c), exp_word(c));
         end
      end
      checks++;
      if ({o_clr[3], o_in1[4], o_in2[4], o_hl[6], o_busy[6], o_busy[7]} !== {1'b1, 8'h0D, 8'h0F, 1'b1, 1'b1, 1'b0}) begin
         errors++;
         $display("FAIL single_timing got clr3=%b in4=%h/%h hl6=%b busy6=%b busy7=%b required 1 0d/0f 1 1 0",
                  o_clr[3], o_in1[4], o_in2[4], o_hl[6], o_busy[6], o_busy[7]);
      end
   endtask

   task automatic test_back_to_back();
      int nclr, nhl;
      do_reset();
      stim.delete();
      add(0, 8'h0D, 8'h0F, 1'b0);
      add(0, 8'h29, 8'h2F, 1'b0);
      add(0, 8'h89, 8'h09, 1'b1);
      add(3, 8'h01, 8'h01, 1'b0);
      add(0, 8'h89, 8'h82, 1'b1);
      play(24);
      build_model(24);
      nclr = 0;
      nhl  = 0;
      for (int c = 0; c < 24; c++) begin
         checks++;
         if (obs_word(c) !== exp_word(c)) begin
            errors++;
            $display("FAIL back_to_back cyc=%0d got=%h required=%h", c, obs_word(c), exp_word(c));
         end
         nclr += int'(o_clr[c]);
         nhl  += int'(o_hl[c]);
      end
      checks++;
      if ({nclr, nhl} !== {32'd2, 32'd2} || o_ur[23] !== 1'b0 || o_clr[10] !== 1'b1 || o_in1[11] !== 8'h01) begin
         errors++;
         $display("FAIL back_to_back_frames got clr=%0d hl=%0d ur=%b clr10=%b in11=%h required 2 2 0 1 01",
                  nclr, nhl, o_ur[23], o_clr[10], o_in1[11]);
      end
   endtask

   task automatic load_fill();
      stim.delete();
      add(0, 8'($urandom), 8'($urandom), 1'b1);
      add(0, 8'($urandom), 8'($urandom), 1'b1);
      for (int j = 0; j < 10; j++) add(0, 8'($urandom), 8'($urandom), 1'b0);
      add(15, 8'($urandom), 8'($urandom), 1'b1);
   endtask

   task automatic test_fill_underrun();
      do_reset();
      load_fill();
      play(42);
      build_model(42);
      for (int c = 0; c < 42; c++) begin
         checks++;
         if (obs_word(c) !== exp_word(c)) begin
            errors++;
            $display("FAIL fill cyc=%0d got=%h required=%h", c, obs_word(c), exp_word(c));
         end
      end
      checks++;
      if ({o_cnt[10], o_rdy[10], o_cnt[13], o_rdy[13], o_ur[41]} !== {4'd8, 1'b0, 4'd8, 1'b0, 1'b1}
          || pcyc.size() < 11 || pcyc[10] != 14) begin
         errors++;
         $display("FAIL fill_full got cnt10=%0d rdy10=%b cnt13=%0d rdy13=%b ur=%b pushes=%0d required 8 0 8 0 1 push11@14",
                  o_cnt[10], o_rdy[10], o_cnt[13], o_rdy[13], o_ur[41], pcyc.size());
      end
   endtask

   task automatic test_reset_mid();
      do_reset();
      load_fill();
      play(15);
      build_model(15);
      for (int c = 0; c < 15; c++) begin
         checks++;
         if (obs_word(c) !== exp_word(c)) begin
            errors++;
            $display("FAIL reset_mid_pre cyc=%0d got=%h required=%h", c, obs_word(c), exp_word(c));
         end
      end
      reset    = 1'b1;
      wr_valid = 1'b1;
      wr_a     = 8'h11;
      wr_b     = 8'h22;
      wr_last  = 1'b1;
      tick();
      checks++;
      if ({fifo_count, mac_in1, mac_in2, mac_clr, mac_out_HL, busy, underrun} !== 24'd0) begin
         errors++;
         $display("FAIL reset_mid got cnt=%0d in=%h/%h clr=%b hl=%b busy=%b ur=%b required all zero",
                  fifo_count, mac_in1, mac_in2, mac_clr, mac_out_HL, busy, underrun);
      end
      reset    = 1'b0;
      wr_valid = 1'b0;
      for (int c = 0; c < 8; c++) begin
         tick();
         checks++;
         if ({mac_out_HL, mac_clr, fifo_count, busy} !== 7'd0) begin
            errors++;
            $display("FAIL reset_mid_after cyc=%0d got hl=%b clr=%b cnt=%0d busy=%b required 0 0 0 0",
                     c, mac_out_HL, mac_clr, fifo_count, busy);
         end
      end
   endtask

   task automatic test_neg_zero();
      logic [7:0] exp_nz;
`ifdef FEEDER_NEG_ZERO_FILTER_EN
      exp_nz = 8'h00;
`else
      exp_nz = 8'h80;
`endif
      do_reset();
      stim.delete();
      add(0, 8'h80, 8'h05, 1'b1);
      play(10);
      build_model(10);
      for (int c = 0; c < 10; c++) begin
         checks++;
         if (obs_word(c) !== exp_word(c)) begin
            errors++;
            $display("FAIL neg_zero cyc=%0d got=%h required=%h", c, obs_word(c), exp_word(c));
         end
      end
      checks++;
      if ({o_in1[4], o_in2[4]} !== {exp_nz, 8'h05}) begin
         errors++;
         $display("FAIL neg_zero_value got %h/%h required %h/05", o_in1[4], o_in2[4], exp_nz);
      end
   endtask

   task automatic test_random();
      for (int r = 0; r < 4; r++) begin
         int nv, npair;
         do_reset();
         stim.delete();
         nv = $urandom_range(2, 3);
         for (int v = 0; v < nv; v++) begin
            npair = $urandom_range(1, 4);
            for (int j = 0; j < npair; j++) begin
               add((j == 0) ? $urandom_range(0, 4) : $urandom_range(0, 2),
                   8'($urandom), 8'($urandom), (j == npair - 1));
            end
         end
         play(80);
         build_model(80);
         for (int c = 0; c < 80; c++) begin
            checks++;
            if (obs_word(c) !== exp_word(c)) begin
               errors++;
               $display("FAIL random r=%0d cyc=%0d got=%h required=%h", r, c, obs_word(c), exp_word(c));
            end
         end
      end
   endtask

   initial begin
      test_reset();
      test_single();
      test_back_to_back();
      test_fill_underrun();
      test_reset_mid();
      test_neg_zero();
      test_random();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
